// File: rtl/program_loader.sv
// Boot loader: pulls a length-prefixed little-endian program image from the UART
// receive buffer and writes it word by word into instruction memory.
module program_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic        clk,
  input  logic        reset,
  output logic        uart_out_valid,
  input  logic [7:0]  uart_out_data,
  input  logic        uart_out_ready,
  output logic [31:0] mem_in_addr,
  output logic [31:0] mem_in_data,
  output logic        mem_in_valid,
  input  logic        mem_in_ready,
  output logic        load_completed,
  output logic        load_error,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {StLen, StData, StWrite, StDone, StError} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] buf_q, buf_d;     // low three bytes of the word being assembled
  logic [31:0] len_q, len_d;
  logic [15:0] count_q, count_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        uart_valid_q, mem_valid_q, done_q, error_q;

  logic        byte_take;
  logic        write_take;
  logic [31:0] word_full;
  logic [15:0] count_inc;

  assign byte_take  = uart_valid_q && uart_out_ready;
  assign write_take = mem_valid_q && mem_in_ready;
  assign word_full  = {uart_out_data, buf_q};
  assign count_inc  = count_q + 16'd1;

  // Next-state, byte assembly and write bookkeeping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    len_d   = len_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;

    if (byte_take) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0:    buf_d[7:0]   = uart_out_data;
        2'd1:    buf_d[15:8]  = uart_out_data;
        2'd2:    buf_d[23:16] = uart_out_data;
        default: ;
      endcase
    end

    unique case (state_q)
      StLen: begin
        if (byte_take && idx_q == 2'd3) begin
          len_d = word_full;
          if (word_full > MAX_WORDS) begin
            state_d = StError;
          end else if (word_full == 32'd0) begin
            state_d = StDone;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (byte_take && idx_q == 2'd3) begin
          data_d  = word_full;
          addr_d  = ADDR_BASE + {14'd0, count_q, 2'b00};
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (write_take) begin
          count_d = count_inc;
          // Header check guarantees len_q fits in 16 bits here.
          state_d = ({16'd0, count_inc} == len_q) ? StDone : StData;
        end
      end
      StDone:  ;
      StError: ;
      default: state_d = StLen;
    endcase
  end

  // State and datapath registers; outputs are registered decodes of the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StLen;
      idx_q        <= 2'd0;
      buf_q        <= 24'd0;
      len_q        <= 32'd0;
      count_q      <= 16'd0;
      addr_q       <= 32'd0;
      data_q       <= 32'd0;
      uart_valid_q <= 1'b0;
      mem_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      len_q        <= len_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      uart_valid_q <= (state_d == StLen) || (state_d == StData);
      mem_valid_q  <= (state_d == StWrite);
      done_q       <= (state_d == StDone);
      error_q      <= (state_d == StError);
    end
  end

  assign uart_out_valid = uart_valid_q;
  assign mem_in_valid   = mem_valid_q;
  assign mem_in_addr    = addr_q;
  assign mem_in_data    = data_q;
  assign load_completed = done_q;
  assign load_error     = error_q;
  assign word_count     = count_q;

endmodule
